// File: rtl/input_cmd_scheduler.sv
// input_cmd_scheduler
// Turns the held state of five game keys, the current level and a millisecond
// time base into one prioritised valid/ready stream of game commands:
// movement with delayed auto-shift / auto-repeat, rotate, soft/hard drop and
// level-dependent gravity ticks.
module input_cmd_scheduler #(
   parameter int unsigned TICK_DIV     = 100000,
   parameter int unsigned GRAV_BASE_MS = 800,
   parameter int unsigned GRAV_STEP_MS = 50,
   parameter int unsigned GRAV_MIN_MS  = 50,
   parameter int unsigned DAS_MS       = 170,
   parameter int unsigned ARR_MS       = 50,
   parameter logic [8:0]  KEY_LEFT     = 9'h06B,
   parameter logic [8:0]  KEY_RIGHT    = 9'h074,
   parameter logic [8:0]  KEY_ROT      = 9'h075,
   parameter logic [8:0]  KEY_SOFT     = 9'h072,
   parameter logic [8:0]  KEY_HARD     = 9'h029
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [511:0] key_down,
   input  logic [3:0]   level,
   input  logic         game_active,
   output logic         cmd_valid,
   output logic [2:0]   cmd,
   input  logic         cmd_ready
);

   // prescaler width; at least one bit even for a divide-by-one time base
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   // bit positions inside the sampled key vector
   localparam int K_LEFT  = 0;
   localparam int K_RIGHT = 1;
   localparam int K_ROT   = 2;
   localparam int K_SOFT  = 3;
   localparam int K_HARD  = 4;

   // bit positions inside the pending vector (command code = index + 1)
   localparam int P_LEFT  = 0;
   localparam int P_RIGHT = 1;
   localparam int P_ROT   = 2;
   localparam int P_SOFT  = 3;
   localparam int P_HARD  = 4;
   localparam int P_GRAV  = 5;

   localparam logic [2:0] CMD_NONE  = 3'd0;
   localparam logic [2:0] CMD_LEFT  = 3'd1;
   localparam logic [2:0] CMD_RIGHT = 3'd2;
   localparam logic [2:0] CMD_ROT   = 3'd3;
   localparam logic [2:0] CMD_SOFT  = 3'd4;
   localparam logic [2:0] CMD_HARD  = 3'd5;
   localparam logic [2:0] CMD_GRAV  = 3'd6;

   localparam logic [15:0] BASE_C = 16'(GRAV_BASE_MS);
   localparam logic [15:0] STEP_C = 16'(GRAV_STEP_MS);
   localparam logic [15:0] MIN_C  = 16'(GRAV_MIN_MS);
   localparam logic [15:0] DAS_C  = 16'(DAS_MS);
   localparam logic [15:0] RPT_C  = 16'(DAS_MS + ARR_MS);

   // gravity period in ms: base minus level reduction, floored at zero, then
   // clamped to the minimum period
   function automatic logic [15:0] grav_period_f(input logic [3:0] lvl);
      logic [15:0] red;
      logic [15:0] diff;
      red = 16'(lvl) * STEP_C;
      if (red >= BASE_C) begin
         diff = 16'd0;
      end else begin
         diff = BASE_C - red;
      end
      if (diff < MIN_C) begin
         grav_period_f = MIN_C;
      end else begin
         grav_period_f = diff;
      end
   endfunction

   // registered state
   logic [4:0]    key_cur_r;
   logic [4:0]    key_prv_r;
   logic [PW-1:0] presc_r;
   logic [15:0]   grav_cnt_r;
   logic [15:0]   hold_cnt_r [3];
   logic [5:0]    pend_r;
   logic          cmd_valid_r;
   logic [2:0]    cmd_r;

   // combinational helpers
   logic [4:0]    key_s;
   logic [4:0]    edge_s;
   logic          tick_s;
   logic [15:0]   grav_period_s;
   logic [15:0]   grav_nxt_s;
   logic          grav_fire_s;
   logic [2:0]    rep_held_s;
   logic [2:0]    rep_edge_s;
   logic [2:0]    rep_en_s;
   logic          lr_both_s;
   logic [15:0]   hold_nxt_s [3];
   logic [2:0]    rep_fire_s;
   logic [5:0]    ev_s;
   logic          load_s;
   logic [2:0]    sel_cmd_s;
   logic [5:0]    sel_clr_s;
   logic [5:0]    pend_nxt_s;
   logic          grav_clr_s;
   logic          key_unused_s;

   // only five scan codes matter; the rest of the key map is intentionally ignored
   assign key_unused_s = ^key_down;

   assign key_s = {key_down[KEY_HARD], key_down[KEY_SOFT], key_down[KEY_ROT],
                   key_down[KEY_RIGHT], key_down[KEY_LEFT]};

   assign edge_s        = key_cur_r & ~key_prv_r;
   assign tick_s        = game_active & (presc_r == PRESC_LAST);
   assign grav_period_s = grav_period_f(level);

   // auto-repeat keys in slot order: 0 LEFT, 1 RIGHT, 2 SOFT_DROP
   assign lr_both_s  = key_cur_r[K_LEFT] & key_cur_r[K_RIGHT];
   assign rep_held_s = {key_cur_r[K_SOFT], key_cur_r[K_RIGHT], key_cur_r[K_LEFT]};
   assign rep_edge_s = {edge_s[K_SOFT], edge_s[K_RIGHT], edge_s[K_LEFT]};
   assign rep_en_s   = {1'b1, ~lr_both_s, ~lr_both_s};

   assign cmd_valid = cmd_valid_r;
   assign cmd       = cmd_r;

   // hold counters: restart on press, count ticks while held, fire at DAS then every ARR
   always_comb begin
      rep_fire_s = 3'b000;
      for (int i = 0; i < 3; i++) begin
         hold_nxt_s[i] = hold_cnt_r[i];
         if (!rep_held_s[i] || rep_edge_s[i] || !rep_en_s[i]) begin
            hold_nxt_s[i] = 16'd0;
         end else if (tick_s) begin
            if ((hold_cnt_r[i] + 16'd1) == DAS_C) begin
               hold_nxt_s[i] = hold_cnt_r[i] + 16'd1;
               rep_fire_s[i] = 1'b1;
            end else if ((hold_cnt_r[i] + 16'd1) == RPT_C) begin
               // fold back to DAS so each further ARR interval fires again
               hold_nxt_s[i] = DAS_C;
               rep_fire_s[i] = 1'b1;
            end else begin
               hold_nxt_s[i] = hold_cnt_r[i] + 16'd1;
            end
         end else begin
            hold_nxt_s[i] = hold_cnt_r[i];
         end
      end
   end

   // new events this cycle, one bit per command
   always_comb begin
      ev_s          = 6'b000000;
      ev_s[P_LEFT]  = edge_s[K_LEFT]  | rep_fire_s[0];
      ev_s[P_RIGHT] = edge_s[K_RIGHT] | rep_fire_s[1];
      ev_s[P_ROT]   = edge_s[K_ROT];
      ev_s[P_SOFT]  = edge_s[K_SOFT]  | rep_fire_s[2];
      ev_s[P_HARD]  = edge_s[K_HARD];
      ev_s[P_GRAV]  = grav_fire_s;
   end

   // fixed-priority pick of the pending command and the flags it retires
   always_comb begin
      sel_cmd_s = CMD_NONE;
      sel_clr_s = 6'b000000;
      if (pend_r[P_HARD]) begin
         sel_cmd_s = CMD_HARD;
         sel_clr_s[P_HARD] = 1'b1;
         // a hard drop makes any queued soft drop or gravity step meaningless
         sel_clr_s[P_SOFT] = 1'b1;
         sel_clr_s[P_GRAV] = 1'b1;
      end else if (pend_r[P_ROT]) begin
         sel_cmd_s = CMD_ROT;
         sel_clr_s[P_ROT] = 1'b1;
      end else if (pend_r[P_LEFT]) begin
         sel_cmd_s = CMD_LEFT;
         sel_clr_s[P_LEFT] = 1'b1;
      end else if (pend_r[P_RIGHT]) begin
         sel_cmd_s = CMD_RIGHT;
         sel_clr_s[P_RIGHT] = 1'b1;
      end else if (pend_r[P_SOFT]) begin
         sel_cmd_s = CMD_SOFT;
         sel_clr_s[P_SOFT] = 1'b1;
      end else if (pend_r[P_GRAV]) begin
         sel_cmd_s = CMD_GRAV;
         sel_clr_s[P_GRAV] = 1'b1;
      end else begin
         sel_cmd_s = CMD_NONE;
         sel_clr_s = 6'b000000;
      end
   end

   // output-load decision, pending update and gravity counter update
   always_comb begin
      load_s     = ~cmd_valid_r | cmd_ready;
      grav_clr_s = 1'b0;
      pend_nxt_s = pend_r | ev_s;
      if (load_s) begin
         // events landing on a flag being retired this cycle keep it set
         pend_nxt_s = (pend_r & ~sel_clr_s) | ev_s;
         case (sel_cmd_s)
            CMD_HARD: grav_clr_s = 1'b1;
            CMD_SOFT: grav_clr_s = 1'b1;
            default:  grav_clr_s = 1'b0;
         endcase
      end else begin
         pend_nxt_s = pend_r | ev_s;
      end

      grav_fire_s = 1'b0;
      grav_nxt_s  = grav_cnt_r;
      if (tick_s) begin
         if (({1'b0, grav_cnt_r} + 17'd1) >= {1'b0, grav_period_s}) begin
            grav_fire_s = 1'b1;
            grav_nxt_s  = 16'd0;
         end else begin
            grav_nxt_s  = grav_cnt_r + 16'd1;
         end
      end else begin
         grav_nxt_s = grav_cnt_r;
      end
      if (grav_clr_s) begin
         grav_nxt_s = 16'd0;
      end else begin
         grav_nxt_s = grav_nxt_s;
      end
   end

   // state registers; pausing flushes everything except the key history so
   // keys already held when play resumes do not look like fresh presses
   always_ff @(posedge clk) begin
      if (rst) begin
         key_cur_r   <= 5'b00000;
         key_prv_r   <= 5'b00000;
         presc_r     <= '0;
         grav_cnt_r  <= 16'd0;
         for (int i = 0; i < 3; i++) begin
            hold_cnt_r[i] <= 16'd0;
         end
         pend_r      <= 6'b000000;
         cmd_valid_r <= 1'b0;
         cmd_r       <= CMD_NONE;
      end else if (!game_active) begin
         key_cur_r   <= key_s;
         key_prv_r   <= key_cur_r;
         presc_r     <= '0;
         grav_cnt_r  <= 16'd0;
         for (int i = 0; i < 3; i++) begin
            hold_cnt_r[i] <= 16'd0;
         end
         pend_r      <= 6'b000000;
         cmd_valid_r <= 1'b0;
         cmd_r       <= CMD_NONE;
      end else begin
         key_cur_r  <= key_s;
         key_prv_r  <= key_cur_r;
         if (presc_r == PRESC_LAST) begin
            presc_r <= '0;
         end else begin
            presc_r <= presc_r + PW'(1);
         end
         grav_cnt_r <= grav_nxt_s;
         for (int i = 0; i < 3; i++) begin
            hold_cnt_r[i] <= hold_nxt_s[i];
         end
         pend_r <= pend_nxt_s;
         if (load_s) begin
            cmd_valid_r <= (sel_cmd_s != CMD_NONE);
            cmd_r       <= sel_cmd_s;
         end
      end
   end

endmodule

// File: tb/tb_input_cmd_scheduler.sv
// Directed bench for input_cmd_scheduler with a scaled-down time base.
module tb_input_cmd_scheduler;

   localparam logic [8:0] KL = 9'h06B;
   localparam logic [8:0] KR = 9'h074;
   localparam logic [8:0] KO = 9'h075;
   localparam logic [8:0] KS = 9'h072;
   localparam logic [8:0] KH = 9'h029;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [511:0] key_down = '0;
   logic [3:0]   level = 4'd0;
   logic         game_active = 1'b0;
   logic         cmd_ready = 1'b0;
   logic         cmd_valid;
   logic [2:0]   cmd;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   input_cmd_scheduler #(
      .TICK_DIV(4), .GRAV_BASE_MS(20), .GRAV_STEP_MS(2), .GRAV_MIN_MS(4),
      .DAS_MS(6), .ARR_MS(2),
      .KEY_LEFT(KL), .KEY_RIGHT(KR), .KEY_ROT(KO), .KEY_SOFT(KS), .KEY_HARD(KH)
   ) dut (
      .clk(clk), .rst(rst), .key_down(key_down), .level(level),
      .game_active(game_active), .cmd_valid(cmd_valid), .cmd(cmd),
      .cmd_ready(cmd_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // pause for two cycles with keys released, then resume (clears all state)
   task automatic restart();
      game_active = 1'b0;
      key_down    = '0;
      step(2);
      game_active = 1'b1;
   endtask

   // wait for a valid command with the given code; t = cycle stamp or -1
   task automatic wait_cmd(input logic [2:0] c, input int budget, output int t);
      t = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (cmd_valid === 1'b1 && cmd === c) begin
            t = cyc;
            break;
         end
      end
   endtask

   initial begin
      int t0, t1, t2, t3, th, d, n_l, n_r, n_late, first, seen_cmd, n_any;

      // reset state
      step(3);
      check_eq("rst_valid", cmd_valid, 0);
      check_eq("rst_cmd", cmd, 0);
      rst = 1'b0;

      // 1: gravity period at level 0 then clamped at level 10
      level = 4'd0; cmd_ready = 1'b1; restart();
      wait_cmd(3'd6, 200, t0); wait_cmd(3'd6, 100, t1); wait_cmd(3'd6, 100, t2);
      check_eq("t1_seen", int'(t0 >= 0 && t1 >= 0 && t2 >= 0), 1);
      check_eq("t1_l0_period_a", t1 - t0, 80);
      check_eq("t1_l0_period_b", t2 - t1, 80);
      level = 4'd10;
      wait_cmd(3'd6, 100, t0); wait_cmd(3'd6, 40, t1);
      wait_cmd(3'd6, 40, t2); wait_cmd(3'd6, 40, t3);
      check_eq("t1_l10_seen", int'(t0 >= 0 && t1 >= 0 && t2 >= 0 && t3 >= 0), 1);
      check_eq("t1_l10_period_a", t2 - t1, 16);
      check_eq("t1_l10_period_b", t3 - t2, 16);

      // 2: LEFT held 44 cycles -> first at edge+2, repeats at hold ticks 6/8/10
      level = 4'd0; cmd_ready = 1'b1; restart();
      key_down[KL] = 1'b1;
      n_l = 0; n_late = 0;
      for (int i = 1; i <= 70; i++) begin
         step(1);
         if (i == 2) check_eq("t2_lat_idle_n2", cmd_valid, 0);
         if (i == 3) begin
            check_eq("t2_lat_valid_n3", cmd_valid, 1);
            check_eq("t2_lat_cmd_n3", cmd, 1);
         end
         if (cmd_valid === 1'b1 && cmd === 3'd1) begin
            n_l++;
            if (i >= 48) n_late++;
         end
         if (i == 44) key_down[KL] = 1'b0;
      end
      check_eq("t2_left_total", n_l, 4);
      check_eq("t2_left_after_release", n_late, 0);

      // 3: simultaneous ROT/LEFT/HARD with stalled output, then drain
      cmd_ready = 1'b0; restart();
      key_down[KO] = 1'b1; key_down[KL] = 1'b1; key_down[KH] = 1'b1;
      step(2);
      key_down = '0;
      step(1);
      check_eq("t3_valid", cmd_valid, 1);
      check_eq("t3_cmd_hard", cmd, 5);
      for (int i = 0; i < 3; i++) begin
         step(1);
         check_eq("t3_hold_stable", int'(cmd_valid === 1'b1 && cmd === 3'd5), 1);
      end
      cmd_ready = 1'b1;
      step(1);
      check_eq("t3_second_rot", int'(cmd_valid === 1'b1 && cmd === 3'd3), 1);
      step(1);
      check_eq("t3_third_left", int'(cmd_valid === 1'b1 && cmd === 3'd1), 1);
      step(1);
      check_eq("t3_drained", cmd_valid, 0);

      // 4: HARD drop flushes pending SOFT and GRAVITY and restarts gravity
      level = 4'd0; cmd_ready = 1'b0; restart();
      key_down[KO] = 1'b1; step(2); key_down[KO] = 1'b0;
      key_down[KS] = 1'b1; step(2); key_down[KS] = 1'b0;
      step(91);
      key_down[KH] = 1'b1; step(2); key_down[KH] = 1'b0;
      step(3);
      check_eq("t4_hold_rot", int'(cmd_valid === 1'b1 && cmd === 3'd3), 1);
      cmd_ready = 1'b1;
      step(1);
      check_eq("t4_hard_next", int'(cmd_valid === 1'b1 && cmd === 3'd5), 1);
      th = cyc; seen_cmd = -1; d = -1;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (cmd_valid === 1'b1) begin
            seen_cmd = int'(cmd);
            d = cyc - th;
            break;
         end
      end
      check_eq("t4_next_is_grav", seen_cmd, 6);
      check_eq("t4_grav_delay_78_to_81", int'(d >= 78 && d <= 81), 1);

      // 5: LEFT+RIGHT held together -> one of each, no repeats
      cmd_ready = 1'b1; restart();
      key_down[KL] = 1'b1; key_down[KR] = 1'b1;
      n_l = 0; n_r = 0; first = 0;
      for (int i = 1; i <= 80; i++) begin
         step(1);
         if (cmd_valid === 1'b1 && cmd === 3'd1) begin
            n_l++;
            if (first == 0) first = 1;
         end
         if (cmd_valid === 1'b1 && cmd === 3'd2) begin
            n_r++;
            if (first == 0) first = 2;
         end
         if (i == 60) key_down = '0;
      end
      check_eq("t5_left_count", n_l, 1);
      check_eq("t5_right_count", n_r, 1);
      check_eq("t5_left_first", first, 1);

      // 6a: pause while a command is stalled
      cmd_ready = 1'b0; restart();
      key_down[KO] = 1'b1; key_down[KL] = 1'b1; step(2);
      key_down = '0; step(2);
      check_eq("t6a_valid_before", cmd_valid, 1);
      game_active = 1'b0;
      step(1);
      check_eq("t6a_valid_after_pause", cmd_valid, 0);
      step(1);
      game_active = 1'b1; cmd_ready = 1'b1;
      n_any = 0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if (cmd_valid !== 1'b0) n_any++;
      end
      check_eq("t6a_no_stale", n_any, 0);

      // 6b: reset while a command is stalled
      cmd_ready = 1'b0;
      key_down[KO] = 1'b1; key_down[KL] = 1'b1; step(2);
      key_down = '0; step(2);
      check_eq("t6b_valid_before", cmd_valid, 1);
      rst = 1'b1;
      step(1);
      check_eq("t6b_valid_after_rst", cmd_valid, 0);
      check_eq("t6b_cmd_after_rst", cmd, 0);
      rst = 1'b0; cmd_ready = 1'b1;
      n_any = 0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if (cmd_valid !== 1'b0) n_any++;
      end
      check_eq("t6b_no_stale", n_any, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/input_cmd_scheduler.md
Name: input_cmd_scheduler

Overview:
- Converts raw keyboard state and the current level into a single serialized stream of game commands for the game logic.
- Generates gravity drop ticks whose period depends on level.
- Applies delayed auto-shift (DAS) and auto-repeat to held movement keys.
- Arbitrates all pending events by fixed priority onto one valid/ready command channel. Sits between KeyboardDecoder/level logic and the game block.

Parameters:
- TICK_DIV, 100000, clk cycles per 1 ms tick.
- GRAV_BASE_MS, 800, gravity period at level 0 (ms).
- GRAV_STEP_MS, 50, period reduction per level (ms).
- GRAV_MIN_MS, 50, minimum gravity period (ms).
- DAS_MS, 170, hold time before the first auto-repeat (ms).
- ARR_MS, 50, auto-repeat interval after DAS (ms).
- KEY_LEFT, 9'h06B, scan code index for move left.
- KEY_RIGHT, 9'h074, scan code index for move right.
- KEY_ROT, 9'h075, scan code index for rotate.
- KEY_SOFT, 9'h072, scan code index for soft drop.
- KEY_HARD, 9'h029, scan code index for hard drop.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- key_down  in  512  per-scan-code held state from the keyboard decoder.
- level  in  4  current game level, 0..15.
- game_active  in  1  1 = scheduling enabled; 0 = paused or game over.
- cmd_valid  out  1  command available.
- cmd  out  3  1 LEFT, 2 RIGHT, 3 ROTATE, 4 SOFT_DROP, 5 HARD_DROP, 6 GRAVITY.
- cmd_ready  in  1  game accepts the command this cycle.

Behaviour:
- Reset: cmd_valid=0, cmd=0, all pending flags=0, ms prescaler=0, gravity counter=0, hold counters=0, registered key copy=0.
- Key sampling: the five selected key_down bits are registered each cycle. A press edge is current=1 with previous=0.
- ms tick: the prescaler counts 0..TICK_DIV-1 and pulses a tick on wrap. It is free-running while game_active=1 and held at 0 while game_active=0.
- Gravity period: max(GRAV_MIN_MS, GRAV_BASE_MS - level*GRAV_STEP_MS), computed at 16 bits, saturating and never negative.
  - The counter increments on each tick. When the count is >= period, GRAVITY pending is set and the counter clears.
  - A level change takes effect at the next tick; the compare is >=, so a shortened period fires immediately.
- Auto-repeat applies to LEFT, RIGHT and SOFT_DROP.
  - A press edge sets pending and clears that key's hold counter.
  - While the key is held, the hold counter increments per tick.
  - On reaching DAS_MS, pending is set; thereafter pending is set every ARR_MS ticks.
  - Release clears the hold counter.
- ROTATE and HARD_DROP are edge-only and never repeat.
- LEFT and RIGHT held simultaneously: edges still register, but neither repeats until one is released.
- Pending flags, one per command, are sticky until issued. A new event on an already-set flag coalesces into it, so there is no count.
- Arbitration priority: HARD_DROP > ROTATE > LEFT > RIGHT > SOFT_DROP > GRAVITY.
- Output register loads when cmd_valid=0 or (cmd_valid & cmd_ready). It takes the highest-priority pending flag from the previous cycle's state, and that flag clears in the same cycle.
- An event in the same cycle as its flag is cleared by issue leaves the flag set.
- Handshake: cmd and cmd_valid are stable while cmd_valid=1 and cmd_ready=0. One command is transferred per cycle with cmd_ready=1.
- Latency: key edge at cycle N (registered sample) -> pending set at N+1 -> cmd_valid at N+2 when the output is free and the key has top priority.
- When HARD_DROP is loaded into the output, the SOFT_DROP and GRAVITY pending flags clear and the gravity counter clears.
- When SOFT_DROP is loaded, the gravity counter clears.
- game_active=0: next cycle cmd_valid=0, and all pending flags, counters and hold counters clear.
  - Edges occurring while inactive are ignored.
  - Keys held when game_active rises produce no edge.
- rst mid-transfer: next cycle all state returns to reset values, regardless of cmd_ready.

Test Plan:
All scenarios use TICK_DIV=4, GRAV_BASE_MS=20, GRAV_STEP_MS=2, GRAV_MIN_MS=4, DAS_MS=6, ARR_MS=2.
1. level=0, game_active=1, cmd_ready=1, no keys -> cmd=6 pulses exactly every 80 cycles. Then level=10 -> period clamps to 4 ms, giving cmd=6 every 16 cycles.
2. KEY_LEFT held from prescaler phase 0 for 44 cycles -> exactly 4 LEFT commands: the first at edge+2 cycles, then repeats at hold ticks 6, 8 and 10. No commands after release.
3. cmd_ready=0; ROT, LEFT and HARD press in the same cycle -> cmd_valid=1 with cmd=5, held stable. Then cmd_ready=1 -> transfers in order 5, 3, 1 on consecutive cycles.
4. GRAVITY and SOFT_DROP pending while cmd_ready=0 and output holds ROT; HARD pressed -> sequence 3, 5 only, with no 4 or 6. The next GRAVITY arrives a full period after the HARD load.
5. LEFT and RIGHT pressed together and held 60 cycles -> one 1 then one 2, with no repeats.
6. cmd_valid=1, cmd_ready=0, then game_active=0 (repeat with rst=1) -> cmd_valid=0 next cycle, and no stale command is emitted after reactivation.
